// File: rtl/yarc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : yarc_pkg
// Description : Shared types and constants for the YARC pipeline sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package yarc_pkg;

    // Pipeline sequencer modes
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } hcu_state_t;

    localparam int DRAIN_CYCLES = 4;
    localparam int REG_ADDR_W   = 5;
    localparam int DRAIN_CNT_W  = 3;

    localparam logic [DRAIN_CNT_W-1:0] c_DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    // True when the ID instruction reads the register a load in EX is about to write.
    // x0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic load_use_hit(
        input logic                  ex_valid,
        input logic                  ex_load,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic                  use_rs1,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic                  use_rs2,
        input logic [REG_ADDR_W-1:0] rs2
    );
        return ex_valid && ex_load && (ex_rd != '0) &&
               ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage : yarc_pkg
`default_nettype wire

// File: rtl/hcu_mem_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : hcu_mem_watchdog
// Description : Counts consecutive data-memory stall cycles and pulses expire
//               during the MEM_TIMEOUT-th one, so the fault lands on the edge
//               that ends it. Any non-stalled cycle clears the count.
// Revision    : 1.0 - initial release
// ============================================================================
module hcu_mem_watchdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_stall,
    output logic o_expire
);

    localparam int c_CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(MEM_TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_count;

    assign o_expire = i_stall && (r_count == c_LAST);

    // Consecutive-stall counter; a completed or absent access restarts it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_stall) begin
            r_count <= r_count + 1'b1;
        end else begin
            r_count <= '0;
        end
    end

endmodule : hcu_mem_watchdog
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit
// Description : 5-stage pipeline sequencer: load-use bubbles, taken-branch
//               flushes, dmem wait-state freeze with watchdog, debug halt.
//               Optional macro YARC_HCU_PERF_CNT_EN adds stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit
    import yarc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_mem_read,
    input  logic                  id_ex_ins_valid,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    input  logic                  halt_req,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_flush,
    output logic                  halt_ack,
    output logic                  mem_fault
`ifdef YARC_HCU_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events
`endif
);

    hcu_state_t             r_state;
    logic [DRAIN_CNT_W-1:0] r_drain_cnt;

    logic w_mem_stall;
    logic w_load_use;
    logic w_active;
    logic w_wd_stall;
    logic w_wd_expire;

    assign w_mem_stall = dmem_req & ~dmem_ready;
    assign w_load_use  = load_use_hit(id_ex_ins_valid, id_ex_mem_read, id_ex_rd,
                                      id_uses_rs1, id_rs1, id_uses_rs2, id_rs2);
    assign w_active    = (r_state == RUN) || (r_state == DRAIN);
    assign w_wd_stall  = w_active & w_mem_stall;

    hcu_mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_stall  (w_wd_stall),
        .o_expire (w_wd_expire)
    );

    // Same-cycle enable/flush strobes; reset forces a frozen, bubble-filled pipe
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        halt_ack     = 1'b0;
        mem_fault    = 1'b0;
        if (!rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        mem_wb_flush = 1'b1;
                    end else if (ex_branch_taken) begin
                        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (w_load_use) begin
                        // Hold PC and IF/ID, inject one bubble into EX
                        {id_ex_en, ex_mem_en, mem_wb_en} = 3'b111;
                        id_ex_flush = 1'b1;
                    end else begin
                        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                    end
                end
                DRAIN: begin
                    if (w_mem_stall) begin
                        mem_wb_flush = 1'b1;
                    end else begin
                        // Stop fetching; a taken branch still redirects the PC
                        pc_en       = ex_branch_taken;
                        {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 4'b1111;
                        if_id_flush = 1'b1;
                        id_ex_flush = ex_branch_taken;
                    end
                end
                HALTED: begin
                    halt_ack = 1'b1;
                end
                default: begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    mem_wb_flush = 1'b1;
                    mem_fault    = 1'b1;
                end
            endcase
        end
    end

    // Sequencer state and drain progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_wd_expire) begin
                        r_state <= FAULT;
                    end else if (!w_mem_stall && !ex_branch_taken && !w_load_use && halt_req) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (w_wd_expire) begin
                        r_state <= FAULT;
                    end else if (!w_mem_stall) begin
                        if (r_drain_cnt == c_DRAIN_LAST) begin
                            r_state <= HALTED;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= FAULT;
                end
            endcase
        end
    end

`ifdef YARC_HCU_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

    // Free-running event counters, frozen outside RUN/DRAIN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else if (w_active) begin
            if (w_mem_stall ||
                ((r_state == RUN) && !ex_branch_taken && w_load_use)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (!w_mem_stall && ex_branch_taken) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end
`endif

endmodule : hazard_control_unit
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_control_unit
// Description : Self-checking bench; reference model tracks pipeline mode with
//               plain flags and counters derived from the sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;

    localparam int c_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, id_ex_rd;
    logic       id_uses_rs1, id_uses_rs2, id_ex_mem_read, id_ex_ins_valid;
    logic       ex_branch_taken, dmem_req, dmem_ready, halt_req;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, mem_wb_flush, halt_ack, mem_fault;
`ifdef YARC_HCU_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
    bit   [31:0] m_stall_cnt, m_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: mode flags and counters
    bit m_drain, m_halted, m_fault;
    int m_drain_done, m_stall_run;

    hazard_control_unit #(.MEM_TIMEOUT(c_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_ins_valid(id_ex_ins_valid), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush), .halt_ack(halt_ack), .mem_fault(mem_fault)
`ifdef YARC_HCU_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit hazard();
        return id_ex_ins_valid && id_ex_mem_read && (id_ex_rd != 0) &&
               ((id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd));
    endfunction

    // Expected {pc,ifid,idex,exmem,memwb en, ifid,idex,memwb flush, ack, fault}
    function automatic logic [9:0] model_out();
        bit stall;
        stall = dmem_req && !dmem_ready;
        if (!rst)                return 10'b00000_111_00;
        if (m_fault)             return 10'b00000_111_01;
        if (m_halted)            return 10'b00000_000_10;
        if (stall)               return 10'b00000_001_00;
        if (m_drain)             return {ex_branch_taken, 4'b1111, 1'b1, ex_branch_taken, 3'b000};
        if (ex_branch_taken)     return 10'b11111_110_00;
        if (hazard())            return 10'b00111_010_00;
        return 10'b11111_000_00;
    endfunction

    task automatic model_reset();
        m_drain = 0; m_halted = 0; m_fault = 0; m_drain_done = 0; m_stall_run = 0;
`ifdef YARC_HCU_PERF_CNT_EN
        m_stall_cnt = 0; m_flush_cnt = 0;
`endif
    endtask

    // Advance the model by one rising edge using the inputs held across it
    task automatic model_step();
        bit stall;
        stall = dmem_req && !dmem_ready;
        if (!rst) begin
            model_reset();
        end else if (m_fault) begin
            // sticky until reset
        end else if (m_halted) begin
            m_stall_run = 0;
            if (!halt_req) m_halted = 0;
        end else begin
`ifdef YARC_HCU_PERF_CNT_EN
            if (stall || (!m_drain && !ex_branch_taken && hazard())) m_stall_cnt++;
            if (!stall && ex_branch_taken) m_flush_cnt++;
`endif
            if (stall) begin
                m_stall_run++;
                if (m_stall_run == c_TIMEOUT) m_fault = 1;
            end else begin
                m_stall_run = 0;
                if (m_drain) begin
                    m_drain_done++;
                    if (m_drain_done == 4) begin
                        m_drain = 0;
                        m_halted = 1;
                    end
                end else if (!ex_branch_taken && !hazard() && halt_req) begin
                    m_drain = 1;
                    m_drain_done = 0;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [9:0] obs, exp;
        exp = model_out();
        obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush, halt_ack, mem_fault};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
`ifdef YARC_HCU_PERF_CNT_EN
        checks++;
        assert ({stall_cycles, flush_events} === {m_stall_cnt, m_flush_cnt}) else begin
            errors++;
            $error("FAIL %s_perf: observed=%h/%h expected=%h/%h", tag,
                   stall_cycles, flush_events, m_stall_cnt, m_flush_cnt);
        end
`endif
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: check mid-cycle, step model on the edge, return 1ns after it
    task automatic cycle(input string tag);
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; id_ex_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_ex_mem_read = 0; id_ex_ins_valid = 0;
        ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0; halt_req = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        check_outputs("reset_async");
        model_reset();
        cycle("reset_hold");
        rst = 1;
    endtask

    initial begin
        int n;
        bit hold_halt;
        clear_inputs();
        model_reset();
        rst = 0;
        cycle("reset0");
        cycle("reset1");
        rst = 1;
        cycle("first_run");

        // Load-use on rs1, then bubble reaches EX
        id_ex_ins_valid = 1; id_ex_mem_read = 1; id_ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
        cycle("load_use");
        id_ex_ins_valid = 0;
        cycle("load_use_resolved");
        // Load-use on rs2
        id_ex_ins_valid = 1; id_rs1 = 3; id_rs2 = 5; id_uses_rs2 = 1;
        cycle("load_use_rs2");
        // rd = x0 never stalls
        id_ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        cycle("x0_no_stall");
        // Branch wins over load-use
        id_ex_rd = 7; id_rs1 = 7;
        ex_branch_taken = 1;
        cycle("branch_over_lu");
        clear_inputs();

        // Three dmem wait states, then completion
        dmem_req = 1; dmem_ready = 0;
        cycle("mem_stall1"); cycle("mem_stall2"); cycle("mem_stall3");
        dmem_ready = 1;
        cycle("mem_done");
        clear_inputs();

        // Halt pulse: ack after 5 edges, then back to RUN
        halt_req = 1;
        cycle("halt_req");
        n = 1;
        halt_req = 0;
        while (!halt_ack && n < 20) begin cycle("drain"); n++; end
        check_val("halt_latency", n, 5);
        cycle("halted_release");
        check_val("ack_dropped", int'(halt_ack), 0);

        // Halt with one stall during drain: 6 edges
        halt_req = 1;
        cycle("halt_req2");
        n = 1;
        dmem_req = 1; dmem_ready = 0;
        cycle("drain_stall");
        n++;
        dmem_req = 0;
        ex_branch_taken = 1;
        cycle("drain_branch");
        n++;
        ex_branch_taken = 0;
        while (!halt_ack && n < 20) begin cycle("drain2"); n++; end
        check_val("halt_latency_stall", n, 6);
        cycle("halted_hold");
        halt_req = 0;
        cycle("halted_exit");
        cycle("run_after_halt");

        // Reset in the middle of DRAIN
        halt_req = 1;
        cycle("halt_req3");
        cycle("drain3");
        halt_req = 0;
        do_reset();
        cycle("run_after_reset");

        // Watchdog expiry and sticky fault
        dmem_req = 1; dmem_ready = 0;
        n = 0;
        while (!mem_fault && n < 20) begin cycle("wd_stall"); n++; end
        check_val("fault_latency", n, c_TIMEOUT);
        dmem_ready = 1;
        cycle("fault_sticky1");
        clear_inputs();
        cycle("fault_sticky2");
        do_reset();
        cycle("run_after_fault");

        // Randomised traffic against the model
        hold_halt = 0;
        for (int i = 0; i < 800; i++) begin
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_ex_rd        = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            id_ex_mem_read  = 1'($urandom_range(0, 1));
            id_ex_ins_valid = ($urandom_range(0, 3) != 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            dmem_req        = ($urandom_range(0, 2) == 0);
            dmem_ready      = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) hold_halt = ~hold_halt;
            halt_req = hold_halt;
            if (m_fault && $urandom_range(0, 3) == 0) do_reset();
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_hazard_control_unit
`default_nettype wire
